// File: rtl/tsmac_fifo_rx_ckli_if.sv
// Handshake bundle for the RX FIFO: write request/data in, read request in,
// read data and the four occupancy flags out.
interface tsmac_fifo_rx_ckli_if #(
    parameter int DATA_WIDTH = 10
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  wr_full;
    logic                  almost_full;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_en;
    logic                  rd_empty;
    logic                  almost_empty;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, almost_full, rd_data, rd_empty, almost_empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, almost_full, rd_data, rd_empty, almost_empty
    );
endinterface

// File: rtl/tsmac_fifo_rx_ckli.sv
// Single-clock RX FIFO with registered full/empty/almost flags and a
// one-cycle read latency straight out of the storage array.
module tsmac_fifo_rx_ckli #(
    parameter int DATA_WIDTH       = 10,
    parameter int ADDR_WIDTH       = 5,
    parameter int ALMOST_FULL_NUM  = 31,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tsmac_fifo_rx_ckli_if.slave    bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    ptr_t                  occ_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  wr_full_q, wr_full_d;
    logic                  almost_full_q, almost_full_d;
    logic                  rd_empty_q, rd_empty_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  wr_fire;
    logic                  rd_fire;

    // Flags are computed from the post-edge pointers so they reflect the
    // occupancy the FIFO will hold after this edge.
    always_comb begin
        wr_fire        = bus.wr_en && !wr_full_q;
        rd_fire        = bus.rd_en && !rd_empty_q;
        wr_ptr_d       = wr_ptr_q + ptr_t'(wr_fire);
        rd_ptr_d       = rd_ptr_q + ptr_t'(rd_fire);
        occ_d          = wr_ptr_d - rd_ptr_d;
        rd_data_d      = rd_fire ? mem_q[rd_ptr_q[ADDR_WIDTH-1:0]] : rd_data_q;
        wr_full_d      = (int'(occ_d) == DEPTH);
        rd_empty_d     = (int'(occ_d) == 0);
        almost_full_d  = (int'(occ_d) >= ALMOST_FULL_NUM);
        almost_empty_d = (int'(occ_d) <= ALMOST_EMPTY_NUM);
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            rd_data_q      <= '0;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            rd_data_q      <= rd_data_d;
            wr_full_q      <= wr_full_d;
            almost_full_q  <= almost_full_d;
            rd_empty_q     <= rd_empty_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.wr_full      = wr_full_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.rd_empty     = rd_empty_q;
    assign bus.almost_empty = almost_empty_q;

endmodule

// File: tb/tb_tsmac_fifo_rx_ckli.sv
// Directed bench for the RX FIFO: a queue model checked every cycle plus
// hand-computed literal checkpoints along the directed sequence.
module tb_tsmac_fifo_rx_ckli;

    localparam int DW = 10;

    logic clk;
    logic rst_n;

    tsmac_fifo_rx_ckli_if #(.DATA_WIDTH(DW)) bus ();

    tsmac_fifo_rx_ckli #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (5),
        .ALMOST_FULL_NUM (31),
        .ALMOST_EMPTY_NUM(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted words.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd;
    bit            m_wa, m_ra;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_rd = '0;
        end else begin
            m_wa = bus.wr_en && (mq.size() < 32);
            m_ra = bus.rd_en && (mq.size() > 0);
            if (m_ra) m_rd = mq.pop_front();
            if (m_wa) mq.push_back(bus.wr_data);
        end
    end

    always @(negedge clk) begin
        chk("model_rd_data",      int'(bus.rd_data),      int'(m_rd));
        chk("model_wr_full",      int'(bus.wr_full),      int'(mq.size() == 32));
        chk("model_rd_empty",     int'(bus.rd_empty),     int'(mq.size() == 0));
        chk("model_almost_full",  int'(bus.almost_full),  int'(mq.size() >= 31));
        chk("model_almost_empty", int'(bus.almost_empty), int'(mq.size() <= 4));
    end

    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rd_empty",     int'(bus.rd_empty),     1);
        chk("rst_almost_empty", int'(bus.almost_empty), 1);
        chk("rst_wr_full",      int'(bus.wr_full),      0);
        chk("rst_almost_full",  int'(bus.almost_full),  0);
        chk("rst_rd_data",      int'(bus.rd_data),      0);
        rst_n = 1'b1;

        // Fill with 33 words, the last one must be dropped
        for (int i = 0; i < 33; i++) begin
            step(1'b1, DW'(1023 - i), 1'b0);
            if (i == 3)  chk("fill4_almost_empty",  int'(bus.almost_empty), 1);
            if (i == 4)  chk("fill5_almost_empty",  int'(bus.almost_empty), 0);
            if (i == 29) chk("fill30_almost_full",  int'(bus.almost_full),  0);
            if (i == 30) chk("fill31_almost_full",  int'(bus.almost_full),  1);
            if (i == 30) chk("fill31_wr_full",      int'(bus.wr_full),      0);
            if (i == 31) chk("fill32_wr_full",      int'(bus.wr_full),      1);
            if (i == 32) chk("fill33_wr_full",      int'(bus.wr_full),      1);
        end
        step(1'b0, '0, 1'b0);

        // Drain with 33 reads, the last one must be ignored
        for (int i = 0; i < 33; i++) begin
            step(1'b0, '0, 1'b1);
            if (i < 32) chk("drain_rd_data", int'(bus.rd_data), 1023 - i);
            if (i == 30) chk("drain31_rd_empty", int'(bus.rd_empty), 0);
            if (i == 31) chk("drain32_rd_empty", int'(bus.rd_empty), 1);
            if (i == 32) chk("drain33_rd_hold",  int'(bus.rd_data),  992);
        end

        // Occupancy 10, then 40 cycles of simultaneous read/write across wrap
        for (int i = 0; i < 10; i++) step(1'b1, DW'(100 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, DW'(200 + i), 1'b1);
            chk("steady_rd_data", int'(bus.rd_data), (i < 10) ? (100 + i) : (200 + i - 10));
            chk("steady_flags", int'({bus.wr_full, bus.almost_full, bus.rd_empty, bus.almost_empty}), 0);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1);
            chk("steady_tail", int'(bus.rd_data), 230 + i);
        end
        chk("steady_empty", int'(bus.rd_empty), 1);

        // Full with simultaneous read and write: write dropped
        for (int i = 0; i < 32; i++) step(1'b1, DW'(300 + i), 1'b0);
        chk("full_before", int'(bus.wr_full), 1);
        step(1'b1, DW'(999), 1'b1);
        chk("full_rw_rd_data", int'(bus.rd_data), 300);
        chk("full_rw_wr_full", int'(bus.wr_full), 0);
        for (int i = 0; i < 31; i++) step(1'b0, '0, 1'b1);
        chk("full_rw_last",  int'(bus.rd_data),  331);
        chk("full_rw_empty", int'(bus.rd_empty), 1);

        // Empty with simultaneous read and write: write accepted, data held
        step(1'b1, DW'(555), 1'b1);
        chk("empty_rw_rd_data",  int'(bus.rd_data),  331);
        chk("empty_rw_rd_empty", int'(bus.rd_empty), 0);
        step(1'b0, '0, 1'b1);
        chk("empty_rw_readback", int'(bus.rd_data), 555);

        // Asynchronous reset at occupancy 20
        for (int i = 0; i < 20; i++) step(1'b1, DW'(400 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        chk("pre_rst_rd_data", int'(bus.rd_data), 400);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_data",      int'(bus.rd_data),      0);
        chk("arst_rd_empty",     int'(bus.rd_empty),     1);
        chk("arst_almost_empty", int'(bus.almost_empty), 1);
        chk("arst_wr_full",      int'(bus.wr_full),      0);
        chk("arst_almost_full",  int'(bus.almost_full),  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, DW'(777), 1'b0);
        chk("post_rst_rd_empty", int'(bus.rd_empty), 0);
        step(1'b0, '0, 1'b1);
        chk("post_rst_rd_data",  int'(bus.rd_data),  777);
        chk("post_rst_empty",    int'(bus.rd_empty), 1);
        step(1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
